// File: rtl/mux_param_sync.sv
// Parameterised N-to-1 lane selector with a registered output and valid flag.
// Optional out-of-range select flag (sel_err) enabled by `define MUX_PARAM_SEL_CHECK_EN.

package mux_pkg;
  localparam int unsigned DWIDTH = 8;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned SEL_W  = $clog2(NUM_IN);

  typedef logic [NUM_IN*DWIDTH-1:0] in_bus_t;
  typedef logic [SEL_W-1:0]         selectr_t;
  typedef logic [DWIDTH-1:0]        dtwidth_t;
endpackage

module mux_param_sync #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DWIDTH-1:0] datain,
  input  logic [SEL_W-1:0]         select,
  input  logic                     in_valid,
  output logic [DWIDTH-1:0]        sltd_o,
`ifdef MUX_PARAM_SEL_CHECK_EN
  output logic                     sel_err,
`endif
  output logic                     out_valid
);

  logic [DWIDTH-1:0] lane_d;
  logic [DWIDTH-1:0] sltd_q;
  logic              valid_q;
`ifdef MUX_PARAM_SEL_CHECK_EN
  logic              hit_d;
  logic              err_q;
`endif

  // Decode by comparison per lane so an out-of-range select matches nothing and yields zero.
  always_comb begin
    lane_d = '0;
`ifdef MUX_PARAM_SEL_CHECK_EN
    hit_d  = 1'b0;
`endif
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (select == SEL_W'(k)) begin
        lane_d = datain[k*DWIDTH +: DWIDTH];
`ifdef MUX_PARAM_SEL_CHECK_EN
        hit_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sltd_q  <= '0;
      valid_q <= 1'b0;
`ifdef MUX_PARAM_SEL_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sltd_q <= lane_d;
      end
`ifdef MUX_PARAM_SEL_CHECK_EN
      err_q   <= in_valid & ~hit_d;
`endif
    end
  end

  assign sltd_o    = sltd_q;
  assign out_valid = valid_q;
`ifdef MUX_PARAM_SEL_CHECK_EN
  assign sel_err   = err_q;
`endif

endmodule

// File: tb/tb_mux_param_sync.sv
// Scoreboard bench for mux_param_sync: a 4-lane and a 3-lane instance driven in parallel,
// expected results queued at stimulus time and checked by an independent monitor.

module tb_mux_param_sync;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] din4;
  logic [1:0]  sel4;
  logic        iv4;
  logic [7:0]  out4;
  logic        ov4;
  logic [23:0] din3;
  logic [1:0]  sel3;
  logic        iv3;
  logic [7:0]  out3;
  logic        ov3;
`ifdef MUX_PARAM_SEL_CHECK_EN
  logic        err4;
  logic        err3;
`endif

  exp_t q4[$];
  exp_t q3[$];
  logic [7:0] hold4, hold3;
  int n_cmp, n_bad;

  mux_param_sync #(.DWIDTH(8), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .datain(din4), .select(sel4), .in_valid(iv4),
    .sltd_o(out4),
`ifdef MUX_PARAM_SEL_CHECK_EN
    .sel_err(err4),
`endif
    .out_valid(ov4)
  );

  mux_param_sync #(.DWIDTH(8), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .datain(din3), .select(sel3), .in_valid(iv3),
    .sltd_o(out3),
`ifdef MUX_PARAM_SEL_CHECK_EN
    .sel_err(err3),
`endif
    .out_valid(ov3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lane_of(input logic [31:0] bus, input int sel, input int n);
    if (sel >= n) return 8'h00;
    return 8'((bus >> (8 * sel)) & 32'hFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One stimulus cycle for both instances; the model decides what each must show after the next edge.
  task automatic step(input logic v4, input logic [1:0] s4, input logic [31:0] d4,
                      input logic v3, input logic [1:0] s3, input logic [23:0] d3);
    exp_t e;
    @(negedge clk);
    iv4 = v4; sel4 = s4; din4 = d4;
    iv3 = v3; sel3 = s3; din3 = d3;
    if (v4) hold4 = lane_of(d4, int'(s4), 4);
    e.v = v4; e.d = hold4; e.e = 1'b0;
    q4.push_back(e);
    if (v3) hold3 = lane_of({8'h00, d3}, int'(s3), 3);
    e.v = v3; e.d = hold3; e.e = v3 && (int'(s3) >= 3);
    q3.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out4"}, 32'(out4), 32'h0);
    check({tag, "_ov4"}, 32'(ov4), 32'h0);
    check({tag, "_out3"}, 32'(out3), 32'h0);
    check({tag, "_ov3"}, 32'(ov3), 32'h0);
`ifdef MUX_PARAM_SEL_CHECK_EN
    check({tag, "_err3"}, 32'(err3), 32'h0);
`endif
  endtask

  // Monitor: pops one expectation per instance after every edge at which stimulus was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (q4.size() > 0) begin
          e = q4.pop_front();
          check("ov4", 32'(ov4), 32'(e.v));
          check("out4", 32'(out4), 32'(e.d));
`ifdef MUX_PARAM_SEL_CHECK_EN
          check("err4", 32'(err4), 32'(e.e));
`endif
        end
        if (q3.size() > 0) begin
          e = q3.pop_front();
          check("ov3", 32'(ov3), 32'(e.v));
          check("out3", 32'(out3), 32'(e.d));
`ifdef MUX_PARAM_SEL_CHECK_EN
          check("err3", 32'(err3), 32'(e.e));
`endif
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    hold4 = 8'h00; hold3 = 8'h00;
    iv4 = 1'b0; sel4 = '0; din4 = 32'hDEADBEEF;
    iv3 = 1'b0; sel3 = '0; din3 = 24'hADBEEF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Lane sweep on two data words, back-to-back valid.
    for (int i = 0; i < 4; i++)
      step(1'b1, 2'(i), 32'hDEADBEEF, 1'b1, 2'(i), 24'hADBEEF);
    for (int i = 0; i < 4; i++)
      step(1'b1, 2'(i), 32'h12345678, 1'b1, 2'(i), 24'h345678);

    // Hold: inputs churn while in_valid is low.
    for (int i = 0; i < 4; i++)
      step(1'b0, 2'($urandom_range(0, 3)), $urandom, 1'b0, 2'($urandom_range(0, 3)), 24'($urandom));

    // Out-of-range select on the 3-lane instance, then recovery.
    step(1'b1, 2'd1, 32'hCAFEF00D, 1'b1, 2'd3, 24'hA1B2C3);
    step(1'b1, 2'd2, 32'hCAFEF00D, 1'b1, 2'd2, 24'hA1B2C3);
    step(1'b1, 2'd0, 32'hCAFEF00D, 1'b1, 2'd3, 24'hA1B2C3);
    step(1'b0, 2'd0, 32'hCAFEF00D, 1'b0, 2'd0, 24'hA1B2C3);

    // Mid-stream reset: a valid sample is set up, then reset lands before its edge.
    step(1'b1, 2'd2, 32'h0BADF00D, 1'b1, 2'd1, 24'h55AA33);
    #2 rst_n = 1'b0;
    q4.delete(); q3.delete();
    hold4 = 8'h00; hold3 = 8'h00;
    #1 check_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd3, 32'h89ABCDEF, 1'b1, 2'd0, 24'h89ABCD);
    step(1'b0, 2'd1, 32'h00000000, 1'b0, 2'd1, 24'h000000);

    // Randomised traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 24'($urandom));

    @(negedge clk);
    @(negedge clk);
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
